// File: rtl/ysyx_22051013_idu_scoreboard_pkg.sv
// ysyx_22051013_idu_scoreboard_pkg: shared widths, constants and issue-state type for the decode scoreboard.
package ysyx_22051013_idu_scoreboard_pkg;
    localparam int REGADDR = 5;
    localparam int NREG_DEF = 32;
    localparam logic [31:0] ZERO32 = 32'h0000_0000;
    localparam logic [REGADDR-1:0] X0 = '0;
    typedef enum logic {ISS_EMPTY, ISS_FULL} iss_state_e;
endpackage

// File: rtl/ysyx_22051013_sb_hazard.sv
// ysyx_22051013_sb_hazard: flags a decode instruction whose sources or destination have a pending write.
module ysyx_22051013_sb_hazard
    import ysyx_22051013_idu_scoreboard_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic [NREG-1:0]    eff_busy_i,
    input  logic               rs1_ena_i,
    input  logic [REGADDR-1:0] rs1_addr_i,
    input  logic               rs2_ena_i,
    input  logic [REGADDR-1:0] rs2_addr_i,
    input  logic               rd_ena_i,
    input  logic [REGADDR-1:0] rd_addr_i,
    output logic               hazard_o
);
    logic rs1_hit, rs2_hit, rd_hit;
    always_comb begin
        // x0 is excluded explicitly so a stray busy bit 0 can never stall decode
        rs1_hit = rs1_ena_i & (rs1_addr_i != X0) & eff_busy_i[rs1_addr_i];
        rs2_hit = rs2_ena_i & (rs2_addr_i != X0) & eff_busy_i[rs2_addr_i];
        rd_hit = rd_ena_i & (rd_addr_i != X0) & eff_busy_i[rd_addr_i];
        hazard_o = rs1_hit | rs2_hit | rd_hit;
    end
endmodule

// File: rtl/ysyx_22051013_idu_scoreboard.sv
// ysyx_22051013_idu_scoreboard: pending-write scoreboard and one-entry issue register between decode and execute.
module ysyx_22051013_idu_scoreboard
    import ysyx_22051013_idu_scoreboard_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter int NREG = NREG_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid_i,
    output logic               id_ready_o,
    input  logic               rs1_ena_i,
    input  logic [REGADDR-1:0] rs1_addr_i,
    input  logic               rs2_ena_i,
    input  logic [REGADDR-1:0] rs2_addr_i,
    input  logic               rd_ena_i,
    input  logic [REGADDR-1:0] rd_addr_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [REGADDR-1:0] ex_rd_addr_o,
    input  logic               wb_valid_i,
    input  logic [REGADDR-1:0] wb_addr_i,
    input  logic               flush_i,
    output logic [NREG-1:0]    busy_o,
    output logic [31:0]        stall_cnt_o
);
    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};
    iss_state_e state_q, state_d;
    logic [NREG-1:0] busy_q, busy_d, eff_busy, wb_clr, rd_set;
    logic [REGADDR-1:0] ex_rd_q, ex_rd_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic hazard, slot_free, fire;

    ysyx_22051013_sb_hazard #(.NREG(NREG)) u_hazard (
        .eff_busy_i(eff_busy),
        .rs1_ena_i (rs1_ena_i),
        .rs1_addr_i(rs1_addr_i),
        .rs2_ena_i (rs2_ena_i),
        .rs2_addr_i(rs2_addr_i),
        .rd_ena_i  (rd_ena_i),
        .rd_addr_i (rd_addr_i),
        .hazard_o  (hazard)
    );

    always_comb begin
        wb_clr = wb_valid_i ? (ONE << wb_addr_i) : '0;
        eff_busy = WB_BYPASS ? (busy_q & ~wb_clr) : busy_q;
        slot_free = (state_q == ISS_EMPTY) | ex_ready_i;
        id_ready_o = ~hazard & slot_free & ~flush_i;
        fire = id_valid_i & id_ready_o;
        rd_set = (fire & rd_ena_i & (rd_addr_i != X0)) ? (ONE << rd_addr_i) : '0;
        // set is OR-ed after the clear so a same-cycle reissue of rd keeps it busy
        busy_d = flush_i ? '0 : ((busy_q & ~wb_clr) | rd_set);
        state_d = flush_i ? ISS_EMPTY : fire ? ISS_FULL : ex_ready_i ? ISS_EMPTY : state_q;
        ex_rd_d = fire ? (rd_ena_i ? rd_addr_i : X0) : ex_rd_q;
        stall_cnt_d = (id_valid_i & hazard & ~flush_i & ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ISS_EMPTY;
            busy_q <= '0;
            ex_rd_q <= X0;
            stall_cnt_q <= ZERO32;
        end else begin
            state_q <= state_d;
            busy_q <= busy_d;
            ex_rd_q <= ex_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid_o = (state_q == ISS_FULL);
    assign ex_rd_addr_o = ex_rd_q;
    assign busy_o = busy_q;
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_ysyx_22051013_idu_scoreboard.sv
// tb_ysyx_22051013_idu_scoreboard: random and directed stimulus checked against a register-array model every cycle.
module tb_ysyx_22051013_idu_scoreboard;
    localparam bit BYP = 1'b1;
    logic clk = 1'b0, rst = 1'b0;
    logic id_valid_i = 0, rs1_ena_i = 0, rs2_ena_i = 0, rd_ena_i = 0;
    logic [4:0] rs1_addr_i = 0, rs2_addr_i = 0, rd_addr_i = 0, wb_addr_i = 0;
    logic ex_ready_i = 0, wb_valid_i = 0, flush_i = 0;
    logic id_ready_o, ex_valid_o;
    logic [4:0] ex_rd_addr_o;
    logic [31:0] busy_o, stall_cnt_o;
    int errs = 0, checks = 0;

    ysyx_22051013_idu_scoreboard #(.WB_BYPASS(BYP), .NREG(32)) dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .rs1_ena_i(rs1_ena_i), .rs1_addr_i(rs1_addr_i), .rs2_ena_i(rs2_ena_i), .rs2_addr_i(rs2_addr_i),
        .rd_ena_i(rd_ena_i), .rd_addr_i(rd_addr_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_rd_addr_o(ex_rd_addr_o), .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .flush_i(flush_i),
        .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // reference model: one pending flag per register, one issue slot, a plain counter
    bit m_busy[32];
    bit m_exv;
    int m_exrd;
    longint m_stall;

    function automatic bit src_blocked(bit en, int a);
        if (!en || a == 0) return 0;
        if (BYP && wb_valid_i && int'(wb_addr_i) == a) return 0;
        return m_busy[a];
    endfunction

    function automatic bit m_hazard();
        return src_blocked(rs1_ena_i, rs1_addr_i) || src_blocked(rs2_ena_i, rs2_addr_i) || src_blocked(rd_ena_i, rd_addr_i);
    endfunction

    function automatic bit m_ready();
        return !m_hazard() && (!m_exv || ex_ready_i) && !flush_i;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = 0;
        for (int i = 1; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_busy[i] <= 0;
            m_exv <= 0;
            m_exrd <= 0;
            m_stall <= 0;
        end else begin
            if (id_valid_i && m_hazard() && !flush_i && m_stall < 64'hFFFF_FFFF) m_stall <= m_stall + 1;
            if (flush_i) begin
                for (int i = 0; i < 32; i++) m_busy[i] <= 0;
                m_exv <= 0;
            end else begin
                if (wb_valid_i) m_busy[wb_addr_i] <= 0;
                if (id_valid_i && m_ready()) begin
                    if (rd_ena_i && rd_addr_i != 0) m_busy[rd_addr_i] <= 1;
                    m_exv <= 1;
                    m_exrd <= rd_ena_i ? int'(rd_addr_i) : 0;
                end else if (ex_ready_i) m_exv <= 0;
            end
        end
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m.id_ready", 32'(id_ready_o), 32'(m_ready()));
        chk("m.ex_valid", 32'(ex_valid_o), 32'(m_exv));
        chk("m.ex_rd", 32'(ex_rd_addr_o), 32'(m_exrd));
        chk("m.busy", busy_o, m_busy_vec());
        chk("m.stall", stall_cnt_o, 32'(m_stall));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(bit v, bit e1, int a1, bit ed, int ad, bit rdy);
        id_valid_i = v;
        rs1_ena_i = e1;
        rs1_addr_i = 5'(a1);
        rs2_ena_i = 0;
        rs2_addr_i = 0;
        rd_ena_i = ed;
        rd_addr_i = 5'(ad);
        ex_ready_i = rdy;
        wb_valid_i = 0;
        flush_i = 0;
    endtask

    initial begin
        #12;
        chk("rst.busy", busy_o, 32'h0);
        chk("rst.ex_valid", 32'(ex_valid_o), 32'h0);
        chk("rst.id_ready", 32'(id_ready_o), 32'h1);
        cyc();
        rst = 1;
        // first issue of rd=5
        drv(1, 0, 0, 1, 5, 1);
        cyc();
        chk("issue5.ex_valid", 32'(ex_valid_o), 32'h1);
        chk("issue5.ex_rd", 32'(ex_rd_addr_o), 32'd5);
        chk("issue5.busy", busy_o, 32'h20);
        // RAW stall on x5 for three cycles
        drv(1, 1, 5, 0, 0, 1);
        #1 chk("raw.id_ready", 32'(id_ready_o), 32'h0);
        repeat (3) cyc();
        chk("raw.stall3", stall_cnt_o, 32'd3);
        wb_valid_i = 1;
        wb_addr_i = 5;
        #1 chk("raw.bypass_ready", 32'(id_ready_o), 32'h1);
        cyc();
        chk("raw.busy_after", busy_o, 32'h0);
        chk("raw.ex_rd_none", 32'(ex_rd_addr_o), 32'd0);
        // x0 is never tracked
        drv(1, 1, 0, 1, 0, 1);
        cyc();
        chk("x0.busy", busy_o, 32'h0);
        chk("x0.stall", stall_cnt_o, 32'd3);
        drv(0, 0, 0, 0, 0, 1);
        wb_valid_i = 1;
        wb_addr_i = 0;
        cyc();
        chk("x0.wb_busy", busy_o, 32'h0);
        // reissue of rd=7 while its prior write retires keeps it busy
        drv(1, 0, 0, 1, 7, 1);
        cyc();
        chk("rd7.first", busy_o, 32'h80);
        wb_valid_i = 1;
        wb_addr_i = 7;
        cyc();
        chk("rd7.set_wins", busy_o, 32'h80);
        drv(0, 0, 0, 0, 0, 1);
        wb_valid_i = 1;
        wb_addr_i = 7;
        cyc();
        chk("rd7.retired", busy_o, 32'h0);
        // execute backpressure
        drv(1, 0, 0, 1, 3, 0);
        cyc();
        chk("bp.ex_rd3", 32'(ex_rd_addr_o), 32'd3);
        drv(1, 0, 0, 1, 4, 0);
        #1 chk("bp.id_ready", 32'(id_ready_o), 32'h0);
        cyc();
        chk("bp.ex_rd_held", 32'(ex_rd_addr_o), 32'd3);
        ex_ready_i = 1;
        #1 chk("bp.release_ready", 32'(id_ready_o), 32'h1);
        cyc();
        chk("bp.ex_rd4", 32'(ex_rd_addr_o), 32'd4);
        drv(0, 0, 0, 0, 0, 1);
        wb_valid_i = 1;
        wb_addr_i = 3;
        cyc();
        wb_addr_i = 4;
        cyc();
        // flush with x8..x11 pending
        for (int r = 8; r < 12; r++) begin
            drv(1, 0, 0, 1, r, 1);
            cyc();
        end
        chk("fl.busy_pre", busy_o, 32'h0000_0F00);
        chk("fl.ex_valid_pre", 32'(ex_valid_o), 32'h1);
        drv(1, 0, 0, 1, 12, 1);
        flush_i = 1;
        wb_valid_i = 1;
        wb_addr_i = 8;
        #1 chk("fl.id_ready", 32'(id_ready_o), 32'h0);
        cyc();
        chk("fl.busy", busy_o, 32'h0);
        chk("fl.ex_valid", 32'(ex_valid_o), 32'h0);
        // async reset in the middle of a stall
        drv(1, 0, 0, 1, 6, 1);
        cyc();
        drv(1, 1, 6, 0, 0, 1);
        repeat (2) cyc();
        #2 rst = 0;
        #1 chk("arst.stall", stall_cnt_o, 32'h0);
        chk("arst.busy", busy_o, 32'h0);
        chk("arst.ex_valid", 32'(ex_valid_o), 32'h0);
        cyc();
        drv(0, 0, 0, 0, 0, 1);
        wb_valid_i = 1;
        wb_addr_i = 6;
        rst = 1;
        cyc();
        // random traffic over a small register window to force hazards
        for (int n = 0; n < 3000; n++) begin
            id_valid_i = ($urandom_range(0, 3) != 0);
            rs1_ena_i = $urandom_range(0, 1);
            rs1_addr_i = 5'($urandom_range(0, 7));
            rs2_ena_i = $urandom_range(0, 1);
            rs2_addr_i = 5'($urandom_range(0, 7));
            rd_ena_i = $urandom_range(0, 1);
            rd_addr_i = 5'($urandom_range(0, 7));
            ex_ready_i = ($urandom_range(0, 3) != 0);
            wb_valid_i = $urandom_range(0, 1);
            wb_addr_i = 5'(($urandom_range(0, 15) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            flush_i = ($urandom_range(0, 39) == 0);
            cyc();
        end
        drv(0, 0, 0, 0, 0, 1);
        cyc();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_22051013_idu_scoreboard.md
# ysyx_22051013_idu_scoreboard

Register-file hazard controller between the decode stage and the execute stage of the ysyx_22051013 core. It keeps a per-register pending-write scoreboard, holds a decoded instruction at decode while any of its source or destination registers has an outstanding write, and issues it to execute through a valid/ready handshake. Writeback retires scoreboard entries. Flush clears all tracking after a pipeline squash.

## Interface
Parameters:
- WB_BYPASS, 1: when 1, a writeback in the same cycle clears a hazard on that register before the compare (regfile is write-first); when 0, the writeback takes effect from the next cycle.
- NREG, 32: number of architectural registers; x0 is never tracked.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  decode holds a valid instruction.
- id_ready_o  out  1  scoreboard accepts the decode instruction this cycle.
- rs1_ena_i / rs1_addr_i  in  1 / 5  source 1 used / index.
- rs2_ena_i / rs2_addr_i  in  1 / 5  source 2 used / index.
- rd_ena_i / rd_addr_i  in  1 / 5  destination written / index.
- ex_valid_o  out  1  issued instruction present toward execute (registered).
- ex_ready_i  in  1  execute accepts the issued instruction.
- ex_rd_addr_o  out  5  rd of the issued instruction; 0 when it has no rd.
- wb_valid_i / wb_addr_i  in  1 / 5  register write completes / index.
- flush_i  in  1  squash; clear all pending state.
- busy_o  out  32  pending-write vector; bit 0 is always 0.
- stall_cnt_o  out  32  count of hazard-stall cycles, saturating.

## Operation
- Scoreboard: 32-bit busy register. Bit r is set on issue of an instruction with rd_ena_i=1 and rd=r≠0. It is cleared on wb_valid_i with wb_addr_i=r.
- Effective busy for the compare: busy, minus bit wb_addr_i when WB_BYPASS=1 and wb_valid_i=1.
- hazard = (rs1_ena_i & eff_busy[rs1]) | (rs2_ena_i & eff_busy[rs2]) | (rd_ena_i & eff_busy[rd]). The rd term is a WAW block. Index 0 never hazards.
- slot_free = ~ex_valid_o | ex_ready_i.
- id_ready_o = ~hazard & slot_free & ~flush_i. This is combinational from the inputs and state.
- fire = id_valid_i & id_ready_o.
- ex_valid_o register:
  - set on fire;
  - cleared on ex_ready_i without fire;
  - held otherwise.
- ex_rd_addr_o is loaded on fire.
- Simultaneous set and clear of the same bit (issue rd=r while wb_addr_i=r): set wins.
- Flush:
  - busy is cleared to 0 and ex_valid_o to 0 next cycle;
  - any writeback or issue in the same cycle is ignored;
  - id_ready_o=0 during flush.
- Writeback to a non-busy register (including x0) has no effect and raises no error.
- stall_cnt_o increments on every cycle with id_valid_i & hazard & ~flush_i, and holds at 0xFFFF_FFFF.
- Two-state issue FSM, tracked by ex_valid_o:
  - EMPTY→FULL on fire.
  - FULL→FULL on fire with ex_ready_i.
  - FULL→EMPTY on ex_ready_i without fire.
  - Any state→EMPTY on flush.

## Timing
- Reset (rst=0, asynchronous): busy_o=0, ex_valid_o=0, ex_rd_addr_o=0, stall_cnt_o=0. id_ready_o follows combinationally (1 when no flush).
- Issue latency: 1 cycle from fire to ex_valid_o=1.
- Back-to-back issue sustains 1 instruction/cycle when ex_ready_i=1 and there is no hazard.
- Dependent instruction after its producer:
  - WB_BYPASS=1: issues in the cycle wb_valid_i for the producer rd is asserted.
  - WB_BYPASS=0: issues one cycle later.
- Reset asserted mid-operation drops all pending state immediately. Writebacks arriving after reset release are harmless.
- No combinational path from ex_valid_o to ex_ready_i is required. id_ready_o depends combinationally on ex_ready_i.

## Structure
- Shared package/define file: REGADDR width (5), NREG (32), the ZERO32 constant, and the x0 index.
- One sub-module, ysyx_22051013_sb_hazard: combinational. Inputs are eff_busy and the three enable/address pairs; output is hazard.
- Busy vector, issue register and stall counter live in the top module.

## Test plan
- Reset, then issue rd=5 (no sources) with ex_ready_i=1:
  - ex_valid_o=1 next cycle, ex_rd_addr_o=5, busy_o=0x20.
- With busy[5]=1, present rs1=5 for 3 cycles:
  - id_ready_o=0 and stall_cnt_o=3.
  - Then wb_valid_i, wb_addr_i=5: with WB_BYPASS=1, fire the same cycle and busy_o=0.
- Issue rd=0 with rs1=0:
  - busy_o stays 0 and no stall occurs.
  - A writeback to x0 leaves busy_o=0.
- Same cycle: issue rd=7 while wb_addr_i=7 clears a prior write → busy[7]=1 afterwards.
- ex_ready_i=0 with ex_valid_o=1:
  - id_ready_o=0 and ex_rd_addr_o is held.
  - Release ex_ready_i=1 → the next instruction issues that cycle.
- Pending busy=0x0000_0F00 and ex_valid_o=1, assert flush_i:
  - next cycle busy_o=0 and ex_valid_o=0.
  - A same-cycle issue is not accepted.
  - Asserting rst low mid-stall zeroes stall_cnt_o asynchronously.
